// File: rtl/execute_stage.sv
// Execute stage of the in-order RV32 pipeline: operand forwarding, ALU drive,
// branch/jump resolution and the EX/MEM pipeline register with a redirect pulse.
module execute_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] pc_in,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  input  logic [4:0]  rd_addr_in,
  input  logic        op1_sel,
  input  logic        op2_sel,
  input  logic [2:0]  func_in,
  input  logic        func_sel_in,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic [2:0]  branch_cond,
  input  logic        mem_load_in,
  input  logic        mem_store_in,
  input  logic [2:0]  mem_size_in,
  input  logic        fwd_mem_valid,
  input  logic [4:0]  fwd_mem_rd,
  input  logic [31:0] fwd_mem_data,
  input  logic        fwd_wb_valid,
  input  logic [4:0]  fwd_wb_rd,
  input  logic [31:0] fwd_wb_data,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [2:0]  alu_func,
  output logic        alu_func_sel,
  input  logic [31:0] alu_out,
  output logic        ready_in,
  output logic        valid_out,
  output logic [31:0] result_out,
  output logic [31:0] store_data_out,
  output logic [4:0]  rd_addr_out,
  output logic        mem_load_out,
  output logic        mem_store_out,
  output logic [2:0]  mem_size_out,
  output logic        branch_taken,
  output logic [31:0] branch_target
);

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } branch_cond_e;

  logic [31:0] fwd_rs1;
  logic [31:0] fwd_rs2;
  logic        cond_true;
  logic        take_transfer;
  logic        is_link;
  logic [31:0] pc_plus_imm;
  logic [31:0] pc_plus_4;
  logic [31:0] jalr_target;
  logic [31:0] target_next;
  logic [31:0] result_next;
  logic        capture;
  logic        redirect;

  // Memory stage is younger than writeback, so it wins; x0 is never forwarded.
  function automatic logic [31:0] forward_operand(
    input logic [4:0]  idx,
    input logic [31:0] rf_data,
    input logic        mem_valid,
    input logic [4:0]  mem_rd,
    input logic [31:0] mem_data,
    input logic        wb_valid,
    input logic [4:0]  wb_rd,
    input logic [31:0] wb_data
  );
    if (idx == 5'd0)                         return rf_data;
    else if (mem_valid && (mem_rd == idx))   return mem_data;
    else if (wb_valid && (wb_rd == idx))     return wb_data;
    else                                     return rf_data;
  endfunction

  assign fwd_rs1 = forward_operand(rs1_addr, rs1_data, fwd_mem_valid, fwd_mem_rd,
                                   fwd_mem_data, fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
  assign fwd_rs2 = forward_operand(rs2_addr, rs2_data, fwd_mem_valid, fwd_mem_rd,
                                   fwd_mem_data, fwd_wb_valid, fwd_wb_rd, fwd_wb_data);

  assign alu_in1      = op1_sel ? pc_in : fwd_rs1;
  assign alu_in2      = op2_sel ? imm   : fwd_rs2;
  assign alu_func     = func_in;
  assign alu_func_sel = func_sel_in;

  always_comb begin
    // NOTE: default assigned first so every path drives cond_true; no latch is inferred.
    cond_true = 1'b0;
    case (branch_cond)
      BR_EQ:   cond_true = (fwd_rs1 == fwd_rs2);
      BR_NE:   cond_true = (fwd_rs1 != fwd_rs2);
      BR_LT:   cond_true = ($signed(fwd_rs1) <  $signed(fwd_rs2));
      BR_GE:   cond_true = ($signed(fwd_rs1) >= $signed(fwd_rs2));
      BR_LTU:  cond_true = (fwd_rs1 <  fwd_rs2);
      BR_GEU:  cond_true = (fwd_rs1 >= fwd_rs2);
      default: cond_true = 1'b0;
    endcase
  end

  assign is_link       = is_jal | is_jalr;
  assign take_transfer = is_link | (is_branch & cond_true);

  assign pc_plus_imm = pc_in + imm;
  assign pc_plus_4   = pc_in + 32'd4;
  assign jalr_target = (fwd_rs1 + imm) & ~32'd1;
  assign target_next = is_jalr ? jalr_target : pc_plus_imm;
  assign result_next = is_link ? pc_plus_4 : alu_out;

  assign ready_in = ~stall;
  assign capture  = ~stall;
  assign redirect = capture & valid_in & ~flush & take_transfer;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out      <= 1'b0;
      result_out     <= '0;
      store_data_out <= '0;
      rd_addr_out    <= '0;
      mem_load_out   <= 1'b0;
      mem_store_out  <= 1'b0;
      mem_size_out   <= '0;
      branch_taken   <= 1'b0;
      branch_target  <= '0;
    end else begin
      // Pulse drops on any non-capturing cycle, stalls included.
      branch_taken <= redirect;
      if (capture) begin
        valid_out      <= valid_in & ~flush;
        result_out     <= result_next;
        store_data_out <= fwd_rs2;
        rd_addr_out    <= rd_addr_in;
        mem_load_out   <= mem_load_in;
        mem_store_out  <= mem_store_in;
        mem_size_out   <= mem_size_in;
      end
      if (redirect) begin
        branch_target <= target_next;
      end
    end
  end

endmodule
